// File: rtl/pooling_forward_max.sv
// pooling_forward_max: streams one k_size-element window of IEEE-754 singles,
// tracks the running maximum and its index, and presents the result to the
// backward pooling stage with a valid/ready handshake.
// Optional feature macro: POOL_FWD_VECT_OUT_EN (adds data_vect_out, the captured window).
module pooling_forward_max #(
  parameter int unsigned k_w    = 3,
  parameter int unsigned k_h    = 3,
  parameter int unsigned k_size = k_w * k_h
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] max_flt_out,
  output logic [7:0]  max_flt_idx
`ifdef POOL_FWD_VECT_OUT_EN
  ,
  output logic [k_size-1:0][31:0] data_vect_out
`endif
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned IDX_W    = 8;
  localparam int unsigned LAST_IDX = k_size - 1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
`ifdef POOL_FWD_VECT_OUT_EN
  logic [k_size-1:0][DATA_W-1:0] vect_q, vect_d;
`endif

  // NaN: all-ones exponent with a non-zero mantissa
  function automatic logic is_nan(input logic [DATA_W-1:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // True when candidate a strictly exceeds running max b (bit-pattern compare)
  function automatic logic flt_gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic res;
    res = 1'b0;
    if (is_nan(a)) begin
      res = 1'b0;
    end else if (is_nan(b)) begin
      res = 1'b1;
    end else if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
      res = 1'b0;
    end else if (a[31] != b[31]) begin
      res = !a[31];
    end else if (!a[31]) begin
      res = a[30:0] > b[30:0];
    end else begin
      res = a[30:0] < b[30:0];
    end
    return res;
  endfunction

  // Next-state: accumulate window elements, then hold the result until taken
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    idx_d   = idx_q;
`ifdef POOL_FWD_VECT_OUT_EN
    vect_d  = vect_q;
`endif
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          if ((cnt_q == IDX_W'(0)) || flt_gt(in_data, max_q)) begin
            max_d = in_data;
            idx_d = cnt_q;
          end
`ifdef POOL_FWD_VECT_OUT_EN
          for (int i = 0; i < int'(k_size); i++) begin
            if (cnt_q == IDX_W'(i)) vect_d[i] = in_data;
          end
`endif
          if (cnt_q == IDX_W'(LAST_IDX)) begin
            cnt_d   = IDX_W'(0);
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACCUM;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
`ifdef POOL_FWD_VECT_OUT_EN
      vect_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
`ifdef POOL_FWD_VECT_OUT_EN
      vect_q  <= vect_d;
`endif
    end
  end

  assign in_ready    = (state_q == ACCUM);
  assign out_valid   = (state_q == HOLD);
  assign max_flt_out = max_q;
  assign max_flt_idx = idx_q;
`ifdef POOL_FWD_VECT_OUT_EN
  assign data_vect_out = vect_q;
`endif

endmodule

// File: tb/tb_pooling_forward_max.sv
// Directed bench for pooling_forward_max (3x3 instance plus a 1x1 instance).
module tb_pooling_forward_max;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, max_flt_out;
  logic [7:0]  max_flt_idx;
  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [31:0] in_data1, max1;
  logic [7:0]  idx1;
`ifdef POOL_FWD_VECT_OUT_EN
  logic [8:0][31:0] data_vect_out;
  logic [0:0][31:0] data_vect_out1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pooling_forward_max #(.k_w(3), .k_h(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .max_flt_out(max_flt_out), .max_flt_idx(max_flt_idx)
`ifdef POOL_FWD_VECT_OUT_EN
    , .data_vect_out(data_vect_out)
`endif
  );

  pooling_forward_max #(.k_w(1), .k_h(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(out_ready1),
    .max_flt_out(max1), .max_flt_idx(idx1)
`ifdef POOL_FWD_VECT_OUT_EN
    , .data_vect_out(data_vect_out1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Feed n elements of w; optional random idle cycles before each element
  task automatic feed(input logic [31:0] w [9], input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) begin
          in_valid = 1'b0;
          in_data  = $urandom();
          @(negedge clk);
        end
      end
      check("in_ready_accum", 32'(in_ready), 32'd1);
      check("out_valid_accum", 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      in_data  = w[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_take", 32'(out_valid), 32'd0);
    check("in_ready_after_take", 32'(in_ready), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [31:0] m, input logic [7:0] ix);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_max"}, max_flt_out, m);
    check({tag, "_idx"}, 32'(max_flt_idx), 32'(ix));
  endtask

  // Monotonic ordering key for non-NaN floats; both zeros map to the same key
  function automatic logic [31:0] okey(input logic [31:0] x);
    if (x[30:0] == 31'd0) return 32'h8000_0000;
    else if (!x[31]) return {1'b1, x[30:0]};
    else return {1'b0, ~x[30:0]};
  endfunction

  function automatic bit nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  task automatic ref_max(input logic [31:0] w [9], output logic [31:0] m, output logic [7:0] ix);
    m  = w[0];
    ix = 8'd0;
    for (int i = 1; i < 9; i++) begin
      if (!nan(w[i]) && (nan(m) || okey(w[i]) > okey(m))) begin
        m  = w[i];
        ix = 8'(i);
      end
    end
  endtask

  logic [31:0] w1 [9] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000, 32'h40800000,
                          32'hBF800000, 32'h00000000, 32'h3FC00000, 32'h40200000};
  logic [31:0] w2 [9] = '{default: 32'hC0000000};
  logic [31:0] w3 [9] = '{32'h7FC00000, 32'hC1000000, 32'hC1000000, 32'hBF000000, 32'hC1000000,
                          32'hC1000000, 32'hC1000000, 32'hC1000000, 32'hC1000000};
  logic [31:0] w4 [9] = '{32'hC1000000, 32'h80000000, 32'hC1000000, 32'hC1000000, 32'hC1000000,
                          32'h00000000, 32'hC1000000, 32'hC1000000, 32'hC1000000};
  logic [31:0] w5 [9] = '{default: 32'h7F000000};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wr [9];
    logic [31:0] em;
    logic [7:0]  ei;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_max", max_flt_out, 32'd0);
    check("rst_idx", 32'(max_flt_idx), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // back-to-back window, consumer always ready
    out_ready = 1'b1;
    feed(w1, 9, 1'b0);
    check_result("w1", 32'h40800000, 8'd4);
`ifdef POOL_FWD_VECT_OUT_EN
    for (int i = 0; i < 9; i++) check("w1_vect", data_vect_out[i], w1[i]);
`endif
    @(negedge clk);
    check("w1_out_valid_drop", 32'(out_valid), 32'd0);
    check("w1_in_ready_back", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    // all ties
    feed(w2, 9, 1'b0);
    check_result("ties", 32'hC0000000, 8'd0);
    consume();

    // NaN first element
    feed(w3, 9, 1'b0);
    check_result("nan", 32'hBF000000, 8'd3);
    consume();

    // -0 / +0 equal, then back-pressure for 5 cycles
    feed(w4, 9, 1'b0);
    check_result("zeros", 32'h80000000, 8'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check_result("stall", 32'h80000000, 8'd1);
    end
    consume();

    // reset mid-window abandons the partial window
    feed(w5, 5, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_max", max_flt_out, 32'd0);
    feed(w1, 9, 1'b1);
    check_result("after_rst", 32'h40800000, 8'd4);
    consume();

    // random windows with input gaps against the reference model
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 9; i++) begin
        case ($urandom_range(7, 0))
          0: wr[i] = 32'h7FC00001;
          1, 2: wr[i] = (i == 0) ? $urandom() : wr[0];
          3: wr[i] = {$urandom_range(1, 0) == 1, 31'd0};
          default: wr[i] = $urandom();
        endcase
      end
      ref_max(wr, em, ei);
      feed(wr, 9, 1'b1);
      check_result("rand", em, ei);
`ifdef POOL_FWD_VECT_OUT_EN
      for (int i = 0; i < 9; i++) check("rand_vect", data_vect_out[i], wr[i]);
`endif
      consume();
    end

    // single-element window instance
    for (int i = 0; i < 3; i++) begin
      check("k1_in_ready", 32'(in_ready1), 32'd1);
      in_valid1 = 1'b1;
      in_data1  = 32'h3F800000 + 32'(i) * 32'h00100000;
      @(negedge clk);
      in_valid1 = 1'b0;
      check("k1_out_valid", 32'(out_valid1), 32'd1);
      check("k1_max", max1, 32'h3F800000 + 32'(i) * 32'h00100000);
      check("k1_idx", 32'(idx1), 32'd0);
      @(negedge clk);
      check("k1_out_valid_drop", 32'(out_valid1), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pooling_forward_max.md
POOLING_FORWARD_MAX -- requirements
Module: pooling_forward_max

Interface
REQ-001 SHALL have parameter k_w, default 3, kernel width.
REQ-002 SHALL have parameter k_h, default 3, kernel height.
REQ-003 SHALL have parameter k_size, default k_w*k_h, elements per window; legal range 1..256.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  in_data holds a valid window element.
REQ-007 SHALL have port in_data  input  32  IEEE-754 single element, raster order within window.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port out_valid  output  1  window result valid.
REQ-010 SHALL have port out_ready  input  1  consumer (backward pooling stage) accepts result.
REQ-011 SHALL have port max_flt_out  output  32  maximum float of the window.
REQ-012 SHALL have port max_flt_idx  output  8  index 0..k_size-1 of that maximum.
REQ-013 SHALL have port data_vect_out  output  32 x k_size  captured window, present only under POOL_FWD_VECT_OUT_EN.

Function
REQ-014 SHALL implement a two-state FSM: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 SHALL accept an element only on a cycle with in_valid=1 and in_ready=1; other cycles leave all state unchanged.
REQ-016 SHALL keep an element counter cnt (0..k_size-1) of accepted elements in the current window; index of an element equals cnt at acceptance.
REQ-017 SHALL load the first element of a window (cnt=0) into the running max and idx=0 unconditionally.
REQ-018 SHALL replace running max/idx with a later element only if it is strictly greater; ties keep the lower index.
REQ-019 SHALL compare floats on bit patterns: positive > negative; both positive compare bits[30:0] ascending; both negative compare bits[30:0] descending; +0 and -0 equal.
REQ-020 SHALL never let a NaN (exp=0xFF, mantissa!=0) replace the running max; a NaN first element SHALL be replaced by the first later non-NaN element.
REQ-021 SHALL move ACCUM->HOLD on acceptance of element k_size-1, clearing cnt to 0; out_valid and results valid the next cycle (1-cycle latency after last element).
REQ-022 SHALL hold max_flt_out, max_flt_idx, data_vect_out stable while out_valid=1 and out_ready=0.
REQ-023 SHALL move HOLD->ACCUM on a cycle with out_valid=1 and out_ready=1; in_ready rises the following cycle (one bubble between windows).
REQ-024 SHALL for k_size=1 enter HOLD after every single accepted element with idx=0.

Reset
REQ-025 SHALL on a clk edge with reset_n=0 enter ACCUM, clear cnt, and drive out_valid=0, max_flt_out=0, max_flt_idx=0, data_vect_out all 0.
REQ-026 SHALL abandon any partial window or held result when reset asserts mid-operation; no result for it is ever presented.
REQ-027 SHALL assert in_ready in the first cycle after reset_n returns high.

Configuration
REQ-028 SHALL, with POOL_FWD_VECT_OUT_EN defined, store each accepted element at data_vect_out[cnt] so the full window is presented with the result for the backward stage.
REQ-029 SHALL, without POOL_FWD_VECT_OUT_EN, omit data_vect_out port and its storage; all other behaviour identical.

Verification
REQ-030 SHALL cover: 3x3 window 1.0,2.0,3.0,0.5,4.0(0x40800000),-1.0,0.0,1.5,2.5 back-to-back, out_ready=1 -> max_flt_out=0x40800000, max_flt_idx=4, out_valid one cycle after 9th accept.
REQ-031 SHALL cover: all nine elements -2.0 (0xC0000000) -> max_flt_out=0xC0000000, max_flt_idx=0 (tie rule).
REQ-032 SHALL cover: element0=NaN 0x7FC00000, element3=-0.5, others -8.0 -> max_flt_out=0xBF000000, idx=3; -0.0 at idx1 with +0.0 at idx5 -> idx=1.
REQ-033 SHALL cover: out_ready held 0 for 5 cycles after out_valid -> in_ready=0, outputs stable; out_ready=1 -> out_valid=0 next cycle, in_ready=1 same cycle.
REQ-034 SHALL cover: reset_n pulsed low after 5 accepted elements, then a fresh 9-element window -> result reflects only the new window, idx counting from 0.
REQ-035 SHALL cover: random in_valid gaps (50% duty) with POOL_FWD_VECT_OUT_EN -> data_vect_out[i] equals i-th accepted element, results match reference model.
